// File: rtl/pulse_capture_sampler_if.sv
// pulse_capture_sampler_if: BRAM write port between the sampler and the sample memory
interface pulse_capture_sampler_if #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 10
);
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              bram_en;
    modport master (output wr_data, wr_addr, wr_en, bram_en);
    modport slave  (input  wr_data, wr_addr, wr_en, bram_en);
endinterface

// File: rtl/pulse_capture_sampler.sv
// pulse_capture_sampler: hysteresis pulse capture of ADC samples into a BRAM write port
module pulse_capture_sampler #(
    parameter int DATA_W  = 10,
    parameter int ADDR_W  = 10,
    parameter int NPEAK_W = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_W-1:0]     adc_dat,
    input  logic [DATA_W-1:0]     hi_thresh,
    input  logic [DATA_W-1:0]     lo_thresh,
    input  logic [15:0]           nsamples,
    input  logic [NPEAK_W-1:0]    npeaks,
    pulse_capture_sampler_if.master bram,
    output logic [ADDR_W:0]       sample_cnt,
    output logic [NPEAK_W-1:0]    peak_cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, REARM, DONE} state_t;
    state_t state, state_nx;
    logic [DATA_W-1:0]  adc_q, hi_q, lo_q;
    logic [15:0]        ns_q, pulse_len, pulse_len_nx;
    logic [NPEAK_W-1:0] np_q, peak_nx;
    logic [ADDR_W-1:0]  addr;
    logic               launch, wr, lo_end, full, cap, pend;
    assign busy = state inside {ARMED, CAPTURE, REARM};
    assign done = state == DONE;
    assign bram.bram_en = busy;
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // write decision, pulse-end detection and next state; a write that fills the buffer wins over the cap
    always_comb begin
        pulse_len_nx = &pulse_len ? pulse_len : pulse_len + 1'b1;
        peak_nx = peak_cnt + 1'b1;
        launch = state == IDLE && start && !abort;
        wr = !abort && ((state == ARMED && adc_q > hi_q) || (state == CAPTURE && adc_q > lo_q));
        lo_end = !abort && state == CAPTURE && adc_q <= lo_q;
        full = wr && &addr;
        cap = wr && |ns_q && pulse_len_nx == ns_q;
        pend = full || cap || lo_end;
        state_nx = state;
        if (abort) state_nx = IDLE;
        else begin
            case (state)
                IDLE:           state_nx = !launch ? IDLE : (npeaks == '0 ? DONE : ARMED);
                ARMED, CAPTURE: state_nx = pend ? ((full || peak_nx == np_q) ? DONE : (cap ? REARM : ARMED))
                                                : (wr ? CAPTURE : state);
                REARM:          state_nx = adc_q <= lo_q ? ARMED : REARM;
                DONE:           state_nx = start ? DONE : IDLE;
                default:        state_nx = IDLE;
            endcase
        end
    end
    // input register, config latch, write port and run counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            ns_q         <= '0;
            np_q         <= '0;
            addr         <= '0;
            pulse_len    <= '0;
            sample_cnt   <= '0;
            peak_cnt     <= '0;
            overflow     <= 1'b0;
            bram.wr_en   <= 1'b0;
            bram.wr_data <= '0;
            bram.wr_addr <= '0;
        end else begin
            adc_q      <= adc_dat;
            bram.wr_en <= wr;
            if (launch) begin
                hi_q       <= hi_thresh;
                lo_q       <= lo_thresh;
                ns_q       <= nsamples;
                np_q       <= npeaks;
                addr       <= '0;
                pulse_len  <= '0;
                sample_cnt <= '0;
                peak_cnt   <= '0;
                overflow   <= 1'b0;
            end else begin
                if (wr) begin
                    bram.wr_data <= adc_q;
                    bram.wr_addr <= addr;
                    addr         <= full ? addr : addr + 1'b1;
                    sample_cnt   <= sample_cnt + 1'b1;
                    pulse_len    <= pulse_len_nx;
                end
                if (pend) begin
                    peak_cnt  <= peak_nx;
                    pulse_len <= '0;
                end
                if (full) overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pulse_capture_sampler.sv
// tb_pulse_capture_sampler: directed checks of capture, hysteresis, cap, overflow, abort and reset
module tb_pulse_capture_sampler;
    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [9:0] adc_dat, hi_thresh, lo_thresh;
    logic [15:0] nsamples;
    logic [8:0] npeaks;
    logic [3:0] sample_cnt;
    logic [8:0] peak_cnt;
    logic       busy, done, overflow;
    int         n_checks = 0, n_pass = 0;
    int         log_a[$], log_d[$], exp_q[$];

    pulse_capture_sampler_if #(.DATA_W(10), .ADDR_W(3)) bif ();

    pulse_capture_sampler #(.DATA_W(10), .ADDR_W(3), .NPEAK_W(9)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .adc_dat(adc_dat),
        .hi_thresh(hi_thresh), .lo_thresh(lo_thresh), .nsamples(nsamples), .npeaks(npeaks),
        .bram(bif), .sample_cnt(sample_cnt), .peak_cnt(peak_cnt),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // record every BRAM write, sampled mid-cycle
    always @(negedge clk) begin
        if (bif.wr_en) begin
            log_a.push_back(int'(bif.wr_addr));
            log_d.push_back(int'(bif.wr_data));
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, log_d.size(), exp_q.size());
        foreach (exp_q[i]) begin
            check($sformatf("%s_d%0d", tag, i), log_d.size() > i ? log_d[i] : -1, exp_q[i]);
            check($sformatf("%s_a%0d", tag, i), log_a.size() > i ? log_a[i] : -1, i);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int v, input int n);
        adc_dat = 10'(v);
        repeat (n) tick;
    endtask

    task automatic launch(input int hi, input int lo, input int ns, input int np);
        hi_thresh = 10'(hi);
        lo_thresh = 10'(lo);
        nsamples  = 16'(ns);
        npeaks    = 9'(np);
        adc_dat   = '0;
        log_a.delete();
        log_d.delete();
        start = 1'b1;
        tick;
    endtask

    task automatic stop;
        start = 1'b0;
        repeat (2) tick;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; adc_dat = '0;
        hi_thresh = '0; lo_thresh = '0; nsamples = '0; npeaks = '0;
        #1;
        check("rst_wr_en", bif.wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", sample_cnt, 0);
        repeat (2) tick;
        rst_n = 1'b1;
        tick;

        launch(100, 80, 0, 1);
        check("t1_busy", busy, 1);
        feed(50, 1); feed(120, 1); feed(130, 1); feed(90, 1); feed(70, 1); feed(0, 3);
        exp_q = {120, 130, 90};
        check_writes("t1");
        check("t1_done", done, 1);
        check("t1_busy_end", busy, 0);
        check("t1_cnt", sample_cnt, 3);
        check("t1_peaks", peak_cnt, 1);
        check("t1_ovf", overflow, 0);
        stop;
        check("t1_idle", done, 0);

        launch(100, 80, 0, 2);
        feed(120, 1); feed(85, 1); feed(95, 1); feed(79, 1); feed(95, 1); feed(101, 1); feed(60, 1); feed(0, 3);
        exp_q = {120, 85, 95, 101};
        check_writes("t2");
        check("t2_done", done, 1);
        check("t2_cnt", sample_cnt, 4);
        check("t2_peaks", peak_cnt, 2);
        stop;

        launch(100, 80, 2, 2);
        feed(150, 10);
        check("t3_rearm_busy", busy, 1);
        check("t3_rearm_peaks", peak_cnt, 1);
        feed(50, 1); feed(150, 1); feed(50, 1); feed(0, 3);
        exp_q = {150, 150, 150};
        check_writes("t3");
        check("t3_done", done, 1);
        check("t3_peaks", peak_cnt, 2);
        check("t3_cnt", sample_cnt, 3);
        stop;

        launch(100, 80, 0, 5);
        feed(200, 12); feed(0, 2);
        exp_q = {200, 200, 200, 200, 200, 200, 200, 200};
        check_writes("t4");
        check("t4_ovf", overflow, 1);
        check("t4_done", done, 1);
        check("t4_peaks", peak_cnt, 1);
        check("t4_cnt", sample_cnt, 8);
        stop;

        launch(100, 80, 0, 1);
        check("t5_ovf_clr", overflow, 0);
        check("t5_cnt_clr", sample_cnt, 0);
        feed(200, 4);
        abort = 1'b1;
        start = 1'b0;
        tick;
        check("t5_ab_wr_en", bif.wr_en, 0);
        check("t5_ab_busy", busy, 0);
        check("t5_ab_cnt", sample_cnt, 3);
        exp_q = {200, 200, 200};
        check_writes("t5");
        repeat (3) tick;
        check("t5_ab_done", done, 0);
        check("t5_ab_cnt_hold", sample_cnt, 3);
        abort = 1'b0;
        tick;
        launch(100, 80, 0, 1);
        check("t5_re_cnt", sample_cnt, 0);
        check("t5_re_peaks", peak_cnt, 0);
        feed(200, 1); feed(50, 1); feed(0, 3);
        exp_q = {200};
        check_writes("t5re");
        check("t5_re_done", done, 1);
        check("t5_re_cnt_end", sample_cnt, 1);
        stop;

        launch(100, 80, 0, 0);
        check("t6_np0_done", done, 1);
        check("t6_np0_busy", busy, 0);
        tick;
        exp_q.delete();
        check_writes("t6");
        stop;
        check("t6_np0_idle", done, 0);

        launch(100, 80, 0, 1);
        feed(200, 3);
        check("t6_pre_busy", busy, 1);
        check("t6_pre_wr_en", bif.wr_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_wr_en", bif.wr_en, 0);
        check("t6_rst_wr_addr", bif.wr_addr, 0);
        check("t6_rst_wr_data", bif.wr_data, 0);
        check("t6_rst_bram_en", bif.bram_en, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_cnt", sample_cnt, 0);
        check("t6_rst_peaks", peak_cnt, 0);
        check("t6_rst_done", done, 0);
        rst_n = 1'b1;
        start = 1'b0;
        tick;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
